edge_pattern_gen: RTL and testbench
===================================

Name: edge_pattern_gen

Overview:
Edge generator, the transmit-side counterpart of the rising/falling edge detector. Accepts single-cycle rise and fall requests and drives a registered level output. Enforces minimum high and low dwell times, queuing at most one pending request per direction. Emits one-cycle rising/falling strobes aligned with each generated transition, so a downstream edge detector sees exactly the edges requested.

Parameters:
MIN_HIGH, 4, minimum cycles level_o stays 1 after a rising edge; legal range >=1.
MIN_LOW, 4, minimum cycles level_o stays 0 after a falling edge; legal range >=1.

Ports:
clk  input  1  clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
rise_req_i  input  1  request a 0->1 transition; single-cycle pulse.
fall_req_i  input  1  request a 1->0 transition; single-cycle pulse.
level_o  output  1  generated waveform; registered.
rising_edge_o  output  1  1 for exactly the first cycle level_o is 1 after a 0->1 change; registered.
falling_edge_o  output  1  1 for exactly the first cycle level_o is 0 after a 1->0 change; registered.
busy_o  output  1  1 while a dwell is in progress or any request is pending.
drop_o  output  1  one-cycle pulse, registered, the cycle after a request is discarded.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: level_o=0, rising_edge_o=0, falling_edge_o=0, drop_o=0, busy_o=0. State=LOW_IDLE, dwell counter=0, pend_rise=0, pend_fall=0. No minimum-low dwell is applied after reset.
- States:
  - LOW_IDLE: level 0, dwell met.
  - LOW_HOLD: level 0, dwell counting.
  - HIGH_IDLE: level 1, dwell met.
  - HIGH_HOLD: level 1, dwell counting.
- Effective request in a cycle = registered pend flag OR the incoming req input.
- Transition timing: a rise accepted in LOW_IDLE at cycle N gives level_o=1 and rising_edge_o=1 at N+1, then state HIGH_HOLD. Fall accepted in HIGH_IDLE is symmetric.
- Dwell: the edge cycle counts as dwell cycle 1.
  - level_o holds for cycles N+1..N+MIN_HIGH (or MIN_LOW).
  - HOLD->IDLE transition happens so that the earliest opposite edge appears at N+MIN_HIGH+1 (or N+MIN_LOW+1).
  - A pending opposite request is executed in the first cycle dwell is met, with no idle gap.
  - Counter width is $clog2(max(MIN_HIGH,MIN_LOW))+1 and it never wraps.
- Pending: during HOLD, an opposite-direction request sets its pend flag.
  - In HIGH_* with pend_fall set, a rise request sets pend_rise and is re-issued after the fall plus MIN_LOW dwell. LOW_* is symmetric.
  - Pend flags clear in the cycle their edge is launched.
- Drops: any request matching the current level with no opposite pend queued, or any request whose pend flag is already set, is discarded. drop_o pulses the next cycle and level_o is unaffected.
- Simultaneous rise_req_i and fall_req_i:
  - In LOW_IDLE: rise launches now and pend_fall is set (pulse of MIN_HIGH cycles).
  - In HIGH_IDLE: fall launches now and pend_rise is set.
  - In HOLD: the opposite one pends and the same-direction one is processed under the drop/pend rules above.
- busy_o = (state is a HOLD) | pend_rise | pend_fall. Registered view, updated with state.
- rising_edge_o and falling_edge_o are never both 1.
- Reset mid-operation: on the cycle after reset is sampled, level_o=0 with no falling_edge_o. Pends and counter are cleared, state is LOW_IDLE and busy_o=0.

Optional Feature:
EDGE_PATTERN_GEN_STATS_EN
- Defined: adds output edge_cnt_o[15:0], counting every cycle rising_edge_o or falling_edge_o is 1.
  - Saturates at 16'hFFFF with no wrap.
  - Cleared to 0 by reset.
  - Registered, updating in the same cycle as the strobe.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. MIN_HIGH=4, MIN_LOW=3. Reset released, rise_req_i at c2 -> level_o=1 from c3, rising_edge_o=1 at c3 only, busy_o=1 c3..c6, 0 from c7.
2. rise_req_i c0, fall_req_i c1 -> level_o=1 c1..c4, level_o=0 and falling_edge_o=1 at c5, no drop_o.
3. rise_req_i and fall_req_i together at c0 in LOW_IDLE -> level_o=1 c1..c4, falling_edge_o at c5. With STATS_EN, edge_cnt_o=2 at c5.
4. rise_req_i c0, fall_req_i c1, rise_req_i c2 -> level_o high c1..c4, low c5..c7, high c8; rising_edge_o at c1 and c8.
5. In HIGH_IDLE, rise_req_i at c10 -> drop_o=1 at c11 only, level_o stays 1. Second fall_req_i while pend_fall set -> drop_o pulse.
6. reset asserted at c2 of HIGH_HOLD with pend_fall set -> at c3 level_o=0, falling_edge_o=0, busy_o=0. A rise_req_i at c4 gives level_o=1 at c5 with no MIN_LOW delay.

Source files
------------

// File: rtl/edge_pattern_gen_if.sv
// ============================================================================
// Module   : edge_pattern_gen_if
// Brief    : Request/strobe bundle between a requester and edge_pattern_gen.
//            The edge_cnt_o member exists only with EDGE_PATTERN_GEN_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface edge_pattern_gen_if;
    logic        rise_req_i;
    logic        fall_req_i;
    logic        level_o;
    logic        rising_edge_o;
    logic        falling_edge_o;
    logic        busy_o;
    logic        drop_o;
`ifdef EDGE_PATTERN_GEN_STATS_EN
    logic [15:0] edge_cnt_o;

    modport master (
        output rise_req_i, fall_req_i,
        input  level_o, rising_edge_o, falling_edge_o, busy_o, drop_o, edge_cnt_o
    );
    modport slave (
        input  rise_req_i, fall_req_i,
        output level_o, rising_edge_o, falling_edge_o, busy_o, drop_o, edge_cnt_o
    );
`else
    modport master (
        output rise_req_i, fall_req_i,
        input  level_o, rising_edge_o, falling_edge_o, busy_o, drop_o
    );
    modport slave (
        input  rise_req_i, fall_req_i,
        output level_o, rising_edge_o, falling_edge_o, busy_o, drop_o
    );
`endif
endinterface

`default_nettype wire

// File: rtl/edge_pattern_gen.sv
// ============================================================================
// Module   : edge_pattern_gen
// Brief    : Level generator with minimum high/low dwell, one pending request
//            per direction and registered edge strobes. Optional edge counter
//            enabled by EDGE_PATTERN_GEN_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_pattern_gen #(
    parameter int MIN_HIGH = 4,
    parameter int MIN_LOW  = 4
) (
    input  logic               clk,
    input  logic               reset,
    edge_pattern_gen_if.slave  bus
);

    localparam int C_MAX_MIN = (MIN_HIGH > MIN_LOW) ? MIN_HIGH : MIN_LOW;
    localparam int C_CNT_W   = $clog2(C_MAX_MIN) + 1;

    localparam logic [C_CNT_W-1:0] C_MIN_HIGH = C_CNT_W'(MIN_HIGH);
    localparam logic [C_CNT_W-1:0] C_MIN_LOW  = C_CNT_W'(MIN_LOW);
    localparam logic [C_CNT_W-1:0] C_ONE      = C_CNT_W'(1);

    typedef enum logic [1:0] {
        LOW_IDLE  = 2'd0,
        LOW_HOLD  = 2'd1,
        HIGH_IDLE = 2'd2,
        HIGH_HOLD = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 pend_rise_q, pend_rise_d;
    logic                 pend_fall_q, pend_fall_d;
    logic                 level_q, level_d;
    logic                 rising_q, rising_d;
    logic                 falling_q, falling_d;
    logic                 busy_q, busy_d;
    logic                 drop_q, drop_d;

    logic                 w_high;
    logic                 w_hold;
    logic [C_CNT_W-1:0]   w_dwell_min;
    logic                 w_dwell_met;
    logic                 w_to_req;
    logic                 w_same_req;
    logic                 w_to_pend;
    logic                 w_same_pend;
    logic                 w_to_pend_n;
    logic                 w_same_pend_n;
    logic                 w_launch;

    // "to" = request toward the opposite level, "same" = request for the current level
    always_comb begin
        w_high        = (state_q == HIGH_IDLE) || (state_q == HIGH_HOLD);
        w_hold        = (state_q == LOW_HOLD)  || (state_q == HIGH_HOLD);
        w_dwell_min   = w_high ? C_MIN_HIGH : C_MIN_LOW;
        w_dwell_met   = !w_hold || (cnt_q >= w_dwell_min);
        w_to_req      = w_high ? bus.fall_req_i : bus.rise_req_i;
        w_same_req    = w_high ? bus.rise_req_i : bus.fall_req_i;
        w_to_pend     = w_high ? pend_fall_q : pend_rise_q;
        w_same_pend   = w_high ? pend_rise_q : pend_fall_q;
        w_launch      = w_dwell_met && (w_to_pend || w_to_req);

        w_to_pend_n   = w_to_pend;
        w_same_pend_n = w_same_pend;
        state_d       = state_q;
        cnt_d         = cnt_q;
        level_d       = level_q;
        rising_d      = 1'b0;
        falling_d     = 1'b0;
        drop_d        = 1'b0;

        if (w_to_req) begin
            if (w_to_pend) begin
                drop_d = 1'b1;
            end else if (!w_dwell_met) begin
                w_to_pend_n = 1'b1;
            end
        end

        // A same-level request is only meaningful behind a queued opposite edge
        if (w_same_req) begin
            if (w_same_pend) begin
                drop_d = 1'b1;
            end else if (w_to_pend || w_to_req) begin
                w_same_pend_n = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end

        if (w_launch) begin
            w_to_pend_n = 1'b0;
            level_d     = !w_high;
            rising_d    = !w_high;
            falling_d   = w_high;
            state_d     = w_high ? LOW_HOLD : HIGH_HOLD;
            cnt_d       = C_ONE;
        end else if (w_hold) begin
            if (w_dwell_met) begin
                state_d = w_high ? HIGH_IDLE : LOW_IDLE;
            end else begin
                cnt_d = cnt_q + C_ONE;
            end
        end

        pend_rise_d = w_high ? w_same_pend_n : w_to_pend_n;
        pend_fall_d = w_high ? w_to_pend_n   : w_same_pend_n;
        busy_d      = (state_d == LOW_HOLD) || (state_d == HIGH_HOLD) ||
                      pend_rise_d || pend_fall_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOW_IDLE;
            cnt_q       <= '0;
            pend_rise_q <= 1'b0;
            pend_fall_q <= 1'b0;
            level_q     <= 1'b0;
            rising_q    <= 1'b0;
            falling_q   <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_rise_q <= pend_rise_d;
            pend_fall_q <= pend_fall_d;
            level_q     <= level_d;
            rising_q    <= rising_d;
            falling_q   <= falling_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.level_o        = level_q;
    assign bus.rising_edge_o  = rising_q;
    assign bus.falling_edge_o = falling_q;
    assign bus.busy_o         = busy_q;
    assign bus.drop_o         = drop_q;

`ifdef EDGE_PATTERN_GEN_STATS_EN
    logic [15:0] edge_cnt_q, edge_cnt_d;

    // Counts alongside the strobe registers so the count moves with the strobe
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if ((rising_d || falling_d) && (edge_cnt_q != 16'hFFFF)) begin
            edge_cnt_d = edge_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_cnt_q <= 16'd0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign bus.edge_cnt_o = edge_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_edge_pattern_gen.sv
// ============================================================================
// Module   : tb_edge_pattern_gen
// Brief    : Directed bench for edge_pattern_gen with MIN_HIGH=4, MIN_LOW=3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edge_pattern_gen;

    localparam int MIN_HIGH = 4;
    localparam int MIN_LOW  = 3;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;

    edge_pattern_gen_if bus ();

    edge_pattern_gen #(
        .MIN_HIGH (MIN_HIGH),
        .MIN_LOW  (MIN_LOW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drive one cycle of requests, then sample 1 time unit after the edge
    task automatic step(input logic r, input logic f);
        bus.rise_req_i = r;
        bus.fall_req_i = f;
        @(posedge clk);
        #1;
        bus.rise_req_i = 1'b0;
        bus.fall_req_i = 1'b0;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic l, input logic r,
                       input logic f, input logic b, input logic d);
        chk1({tag, ".level"},   bus.level_o,        l);
        chk1({tag, ".rising"},  bus.rising_edge_o,  r);
        chk1({tag, ".falling"}, bus.falling_edge_o, f);
        chk1({tag, ".busy"},    bus.busy_o,         b);
        chk1({tag, ".drop"},    bus.drop_o,         d);
`ifdef EDGE_PATTERN_GEN_STATS_EN
        if (r || f) exp_cnt++;
        total++;
        assert (bus.edge_cnt_o === 16'(exp_cnt)) else begin
            bad++;
            $error("FAIL %s.edge_cnt: observed=%0d expected=%0d", tag, bus.edge_cnt_o, exp_cnt);
        end
`endif
    endtask

    initial begin
        reset          = 1'b1;
        bus.rise_req_i = 1'b0;
        bus.fall_req_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        // 1: rise at c2, high dwell of 4, busy through c6
        step(0, 0); chk("t1_c1", 0, 0, 0, 0, 0);
        step(0, 0);
        step(1, 0); chk("t1_c3", 1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0); chk("t1_hold", 1, 0, 0, 1, 0);
        end
        step(0, 0); chk("t1_c7", 1, 0, 0, 0, 0);

        // 5a: same-level rise in HIGH_IDLE is dropped; then fall, low dwell of 3
        step(1, 0); chk("t5_drop", 1, 0, 0, 0, 1);
        step(0, 0); chk("t5_drop_end", 1, 0, 0, 0, 0);
        step(0, 1); chk("t5_fall", 0, 0, 1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0); chk("t5_low_hold", 0, 0, 0, 1, 0);
        end
        step(0, 0); chk("t5_low_idle", 0, 0, 0, 0, 0);

        // 2: rise c0, fall c1 queued, fall edge at c5
        step(1, 0); chk("t2_c1", 1, 1, 0, 1, 0);
        step(0, 1); chk("t2_c2", 1, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0); chk("t2_hold", 1, 0, 0, 1, 0);
        end
        step(0, 0); chk("t2_c5", 0, 0, 1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0); chk("t2_low_hold", 0, 0, 0, 1, 0);
        end
        step(0, 0); chk("t2_c8", 0, 0, 0, 0, 0);

        // 3: simultaneous requests in LOW_IDLE give a MIN_HIGH pulse
        step(1, 1); chk("t3_c1", 1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0); chk("t3_hold", 1, 0, 0, 1, 0);
        end
        step(0, 0); chk("t3_c5", 0, 0, 1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0); chk("t3_low_hold", 0, 0, 0, 1, 0);
        end
        step(0, 0); chk("t3_c8", 0, 0, 0, 0, 0);

        // 4: rise, fall, rise queued behind the fall; re-rise at c8
        step(1, 0); chk("t4_c1", 1, 1, 0, 1, 0);
        step(0, 1); chk("t4_c2", 1, 0, 0, 1, 0);
        step(1, 0); chk("t4_c3", 1, 0, 0, 1, 0);
        step(0, 0); chk("t4_c4", 1, 0, 0, 1, 0);
        step(0, 0); chk("t4_c5", 0, 0, 1, 1, 0);
        step(0, 0); chk("t4_c6", 0, 0, 0, 1, 0);
        step(0, 0); chk("t4_c7", 0, 0, 0, 1, 0);
        step(0, 0); chk("t4_c8", 1, 1, 0, 1, 0);

        // 5b: second fall while pend_fall is set is dropped
        step(0, 1); chk("t5b_c9", 1, 0, 0, 1, 0);
        step(0, 1); chk("t5b_c10", 1, 0, 0, 1, 1);
        step(0, 0); chk("t5b_c11", 1, 0, 0, 1, 0);
        step(0, 0); chk("t5b_c12", 0, 0, 1, 1, 0);
        step(0, 0);
        step(0, 0);
        step(0, 0); chk("t5b_idle", 0, 0, 0, 0, 0);

        // 6: reset in HIGH_HOLD with pend_fall; no falling strobe, no low dwell after
        step(1, 0); chk("t6_c1", 1, 1, 0, 1, 0);
        step(0, 1); chk("t6_c2", 1, 0, 0, 1, 0);
        reset = 1'b1;
        step(0, 0);
        reset = 1'b0;
        exp_cnt = 0;
        chk("t6_c3", 0, 0, 0, 0, 0);
        step(0, 0); chk("t6_c4", 0, 0, 0, 0, 0);
        step(1, 0); chk("t6_c5", 1, 1, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
